pipeline_skid_stage: RTL and testbench

PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

---
 rtl/pipeline_skid_stage_pkg.sv | 18 +
 rtl/pipeline_skid_stage.sv | 101 ++++++++++
 tb/tb_pipeline_skid_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_skid_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipeline_skid_stage_pkg
// Brief    : Shared word size and opcode constants for pipeline stages.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_skid_stage_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam logic [3:0]  OPCODE_NOP = 4'hF;

    // NOP instruction word used to fill an empty stage.
    localparam logic [WORD_SIZE-1:0] BUBBLE_WORD = {OPCODE_NOP, 12'b0};

endpackage

`default_nettype wire

// File: rtl/pipeline_skid_stage.sv
//------------------------------------------------------------------------------
// Module   : pipeline_skid_stage
// Brief    : Two-entry valid/ready skid buffer with flush and NOP bubbles.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_skid_stage
    import pipeline_skid_stage_pkg::*;
#(
    parameter int unsigned      WIDTH  = WORD_SIZE,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_WORD)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Encoding equals the entry count so occupancy comes straight from the flops.
    localparam logic [1:0] C_ST_EMPTY = 2'd0;
    localparam logic [1:0] C_ST_HALF  = 2'd1;
    localparam logic [1:0] C_ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] skid_q,  skid_d;

    logic w_in_xfer;
    logic w_out_xfer;

    assign in_ready   = (state_q != C_ST_FULL);
    assign out_valid  = (state_q != C_ST_EMPTY);
    assign out_data   = out_valid ? head_q : BUBBLE;
    assign occupancy  = state_q;

    assign w_in_xfer  = in_valid  & in_ready;
    assign w_out_xfer = out_ready & out_valid;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = C_ST_EMPTY;
            head_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                C_ST_EMPTY: begin
                    if (w_in_xfer) begin
                        state_d = C_ST_HALF;
                        head_d  = in_data;
                    end
                end
                C_ST_HALF: begin
                    if (w_in_xfer && w_out_xfer) begin
                        head_d = in_data;
                    end else if (w_in_xfer) begin
                        state_d = C_ST_FULL;
                        skid_d  = in_data;
                    end else if (w_out_xfer) begin
                        state_d = C_ST_EMPTY;
                    end
                end
                C_ST_FULL: begin
                    if (w_out_xfer) begin
                        state_d = C_ST_HALF;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = C_ST_EMPTY;
                    head_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= C_ST_EMPTY;
            head_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_skid_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_pipeline_skid_stage
// Brief    : Self-checking bench for pipeline_skid_stage (16-bit and 64-bit).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_skid_stage;

    localparam logic [63:0] C_BUBBLE = 64'hF000;

    logic clk;
    logic reset_n;

    logic        flush16, in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] in_data16, out_data16;
    logic [1:0]  occ16;

    logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] in_data64, out_data64;
    logic [1:0]  occ64;

    int n_cmp;
    int n_fail;

    pipeline_skid_stage #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .occupancy (occ16)
    );

    pipeline_skid_stage #(.WIDTH(64)) u_dut64 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush64),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_data   (in_data64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_data  (out_data64),
        .occupancy (occ64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [15:0] in_data;
        logic        out_ready;
        logic        exp_out_valid;
        logic        exp_in_ready;
        logic [15:0] exp_out_data;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string tag, input logic ov, input logic ir,
                           input logic [15:0] od, input logic [1:0] oc);
        check({tag, ".out_valid"}, 64'(out_valid16), 64'(ov));
        check({tag, ".in_ready"},  64'(in_ready16),  64'(ir));
        check({tag, ".out_data"},  64'(out_data16),  64'(od));
        check({tag, ".occupancy"}, 64'(occ16),       64'(oc));
    endtask

    task automatic drive16(input logic fl, input logic iv, input logic [15:0] d, input logic ordy);
        flush16     = fl;
        in_valid16  = iv;
        in_data16   = d;
        out_ready16 = ordy;
    endtask

    logic [63:0] model_q[$];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset_n = 1'b0;
        drive16(1'b0, 1'b0, 16'h0, 1'b0);
        flush64 = 1'b0; in_valid64 = 1'b0; in_data64 = '0; out_ready64 = 1'b0;

        // {flush, in_valid, in_data, out_ready, exp ov, exp ir, exp data, exp occ}
        vecs[0]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 2'd1};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hF000, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 16'hAAAA, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, 16'hAAAA, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 16'hAAAA, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hBBBB, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hF000, 2'd0};
        vecs[7]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h1111, 2'd1};
        vecs[8]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h1111, 2'd2};
        vecs[9]  = '{1'b1, 1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b1, 16'hF000, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hF000, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h3333, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 1'b1, 16'h4444, 2'd1};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hF000, 2'd0};

        #2;
        check16("reset", 1'b0, 1'b1, 16'hF000, 2'd0);
        check("reset64.out_data", out_data64, C_BUBBLE);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive16(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            @(posedge clk);
            #1;
            check16($sformatf("vec%0d", i), vecs[i].exp_out_valid, vecs[i].exp_in_ready,
                    vecs[i].exp_out_data, vecs[i].exp_occ);
        end

        // Back-to-back streaming: one-cycle latency and no bubbles.
        for (int k = 1; k <= 16; k++) begin
            drive16(1'b0, 1'b1, 16'(k), 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d.data", k), 64'(out_data16), 64'(k));
            check($sformatf("stream%0d.valid", k), 64'(out_valid16), 64'd1);
        end
        drive16(1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        check16("stream_drain", 1'b0, 1'b1, 16'hF000, 2'd0);

        // Fill, then pulse reset between edges.
        drive16(1'b0, 1'b1, 16'h5A5A, 1'b0);
        @(posedge clk); #1;
        drive16(1'b0, 1'b1, 16'hA5A5, 1'b0);
        @(posedge clk); #1;
        check16("prereset_full", 1'b1, 1'b0, 16'h5A5A, 2'd2);
        drive16(1'b0, 1'b0, 16'h0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check16("async_reset", 1'b0, 1'b1, 16'hF000, 2'd0);
        #1;
        reset_n = 1'b1;
        drive16(1'b0, 1'b1, 16'h5555, 1'b1);
        @(posedge clk); #1;
        check16("post_reset", 1'b1, 1'b1, 16'h5555, 2'd1);
        drive16(1'b0, 1'b0, 16'h0, 1'b1);

        // Random traffic on the 64-bit instance against a bounded-queue model.
        for (int c = 0; c < 10000; c++) begin
            logic exp_ov;
            logic in_x, out_x;
            exp_ov = (model_q.size() > 0);
            check("rnd.out_valid", 64'(out_valid64), 64'(exp_ov));
            check("rnd.in_ready",  64'(in_ready64),  64'(model_q.size() < 2));
            check("rnd.occupancy", 64'(occ64),       64'(model_q.size()));
            check("rnd.out_data",  out_data64, exp_ov ? model_q[0] : C_BUBBLE);
            in_valid64  = ($urandom_range(0, 3) != 0);
            out_ready64 = ($urandom_range(0, 2) != 0);
            in_data64   = {$urandom, $urandom};
            in_x  = in_valid64 && (model_q.size() < 2);
            out_x = out_ready64 && exp_ov;
            @(posedge clk);
            #1;
            if (out_x) void'(model_q.pop_front());
            if (in_x)  model_q.push_back(in_data64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
